// File: rtl/otter_exec_unit.sv
// otter_exec_unit: execute-stage block of the pipelined OTTER RV32I core.
// Produces the registered ALU result, the JAL/JALR/branch target addresses
// and the branch compare flags, all with one cycle of latency.
// Optional feature: define EXEC_ZERO_FLAG_EN to add the registered ZERO output,
// which is set when the ALU result being registered is zero.
module otter_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             STALL,
    input  logic [3:0]       ALU_FUN,
    input  logic [WIDTH-1:0] SRC_A,
    input  logic [WIDTH-1:0] SRC_B,
    input  logic [WIDTH-1:0] RS1,
    input  logic [WIDTH-1:0] RS2,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] IMM,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] JAL,
    output logic [WIDTH-1:0] JALR,
    output logic [WIDTH-1:0] BRANCH,
    output logic             BR_EQ,
    output logic             BR_LT,
    output logic             BR_LTU
`ifdef EXEC_ZERO_FLAG_EN
    ,
    output logic             ZERO
`endif
);

    localparam int SHAMT_W = $clog2(WIDTH);

    // JALR targets must be halfword aligned, so bit 0 is always cleared.
    localparam logic [WIDTH-1:0] JALR_MASK = {{(WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0001,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_LUI  = 4'b1001
    } alu_op_e;

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_next;
    logic [WIDTH-1:0]   pc_imm;
    logic [WIDTH-1:0]   rs1_imm;

    // Only the low bits of SRC_B select the shift distance; the rest are ignored.
    assign shamt   = SRC_B[SHAMT_W-1:0];
    assign pc_imm  = PC + IMM;
    assign rs1_imm = RS1 + IMM;

    // ALU operation decode; unknown codes yield zero.
    always_comb begin
        // NOTE: default assigned first so every path drives alu_next and no latch is inferred.
        alu_next = '0;
        case (ALU_FUN)
            ALU_ADD:  alu_next = SRC_A + SRC_B;
            ALU_SUB:  alu_next = SRC_A - SRC_B;
            ALU_OR:   alu_next = SRC_A | SRC_B;
            ALU_AND:  alu_next = SRC_A & SRC_B;
            ALU_XOR:  alu_next = SRC_A ^ SRC_B;
            ALU_SLL:  alu_next = SRC_A << shamt;
            ALU_SRL:  alu_next = SRC_A >> shamt;
            ALU_SRA:  alu_next = $unsigned($signed(SRC_A) >>> shamt);
            ALU_SLT:  alu_next = {{(WIDTH-1){1'b0}}, ($signed(SRC_A) < $signed(SRC_B))};
            ALU_SLTU: alu_next = {{(WIDTH-1){1'b0}}, (SRC_A < SRC_B)};
            ALU_LUI:  alu_next = SRC_A;
            default:  alu_next = '0;
        endcase
    end

    // Output registers: synchronous reset wins over stall; stall holds every output.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            RESULT <= '0;
            JAL    <= '0;
            JALR   <= '0;
            BRANCH <= '0;
            BR_EQ  <= 1'b0;
            BR_LT  <= 1'b0;
            BR_LTU <= 1'b0;
`ifdef EXEC_ZERO_FLAG_EN
            ZERO   <= 1'b0;
`endif
        end else if (!STALL) begin
            // NOTE: non-blocking assignments so all registers update together from pre-edge values.
            RESULT <= alu_next;
            JAL    <= pc_imm;
            JALR   <= rs1_imm & JALR_MASK;
            BRANCH <= pc_imm;
            BR_EQ  <= (RS1 == RS2);
            BR_LT  <= ($signed(RS1) < $signed(RS2));
            BR_LTU <= (RS1 < RS2);
`ifdef EXEC_ZERO_FLAG_EN
            ZERO   <= (alu_next == '0);
`endif
        end
    end

endmodule

// File: tb/tb_otter_exec_unit.sv
// Self-checking bench for otter_exec_unit: a driver issues directed vectors
// and queues the hand-computed response; a monitor pops and compares it on
// the falling edge of the cycle in which the DUT presents that response.
module tb_otter_exec_unit;

    typedef struct {
        int          tag;
        string       name;
        logic [31:0] result;
        logic [31:0] jal;
        logic [31:0] jalr;
        logic [31:0] branch;
        logic        eq;
        logic        lt;
        logic        ltu;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [3:0]  alu_fun;
    logic [31:0] src_a, src_b, rs1, rs2, pc, imm;
    logic [31:0] result, jal, jalr, branch;
    logic        br_eq, br_lt, br_ltu;
`ifdef EXEC_ZERO_FLAG_EN
    logic        zero;
`endif

    exp_t sb[$];
    exp_t last_exp;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    otter_exec_unit #(.WIDTH(32)) dut (
        .CLK     (clk),
        .RST     (rst),
        .STALL   (stall),
        .ALU_FUN (alu_fun),
        .SRC_A   (src_a),
        .SRC_B   (src_b),
        .RS1     (rs1),
        .RS2     (rs2),
        .PC      (pc),
        .IMM     (imm),
        .RESULT  (result),
        .JAL     (jal),
        .JALR    (jalr),
        .BRANCH  (branch),
        .BR_EQ   (br_eq),
        .BR_LT   (br_lt),
        .BR_LTU  (br_ltu)
`ifdef EXEC_ZERO_FLAG_EN
        ,
        .ZERO    (zero)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare the queued response due in this cycle against the outputs.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".tag"},    32'(e.tag), 32'(cyc));
            check({e.name, ".result"}, result, e.result);
            check({e.name, ".jal"},    jal,    e.jal);
            check({e.name, ".jalr"},   jalr,   e.jalr);
            check({e.name, ".branch"}, branch, e.branch);
            check({e.name, ".eq"},     32'(br_eq),  32'(e.eq));
            check({e.name, ".lt"},     32'(br_lt),  32'(e.lt));
            check({e.name, ".ltu"},    32'(br_ltu), 32'(e.ltu));
`ifdef EXEC_ZERO_FLAG_EN
            check({e.name, ".zero"},   32'(zero),   32'(e.zero));
`endif
        end
    end

    // Drive one cycle of inputs, queue the response expected one cycle later.
    task automatic issue(input string name, input logic r, input logic s,
                         input logic [3:0] fun, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] p, input logic [31:0] im,
                         input logic [31:0] e_res, input logic [31:0] e_jal,
                         input logic [31:0] e_jalr, input logic e_eq, input logic e_lt,
                         input logic e_ltu, input logic e_zero);
        exp_t e;
        rst = r; stall = s; alu_fun = fun;
        src_a = a; src_b = b; rs1 = r1; rs2 = r2; pc = p; imm = im;
        e.tag = cyc + 1; e.name = name;
        e.result = e_res; e.jal = e_jal; e.jalr = e_jalr; e.branch = e_jal;
        e.eq = e_eq; e.lt = e_lt; e.ltu = e_ltu; e.zero = e_zero;
        sb.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
    endtask

    // ALU-only vector: compare/target inputs are zero, so targets are 0 and RS1==RS2.
    task automatic alu_vec(input string name, input logic [3:0] fun,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] e_res);
        issue(name, 1'b1, 1'b0, fun, a, b, 0, 0, 0, 0, e_res, 0, 0, 1'b1, 1'b0, 1'b0, e_res == 0);
    endtask

    // Stalled cycle: new inputs are presented but the previous response must hold.
    task automatic stall_vec(input string name, input logic [31:0] a, input logic [31:0] b);
        exp_t held;
        held = last_exp;
        issue(name, 1'b1, 1'b1, 4'b0000, a, b, a, b, b, a,
              held.result, held.jal, held.jalr, held.eq, held.lt, held.ltu, held.zero);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; stall = 1'b0; alu_fun = '0;
        src_a = '0; src_b = '0; rs1 = '0; rs2 = '0; pc = '0; imm = '0;
        @(posedge clk);
        #1;

        // Reset with random inputs: everything clears, flags included.
        for (int i = 0; i < 2; i++)
            issue("reset", 1'b0, 1'($urandom), 4'($urandom), $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        alu_vec("add_5_7",    4'b0000, 32'd5,          32'd7,          32'd12);
        alu_vec("sub_wrap",   4'b1000, 32'd0,          32'd1,          32'hFFFF_FFFF);
        alu_vec("add_wrap",   4'b0000, 32'hFFFF_FFFF,  32'd2,          32'd1);
        alu_vec("sra",        4'b1101, 32'h8000_0000,  32'h24,         32'hF800_0000);
        alu_vec("srl",        4'b0101, 32'h8000_0000,  32'h24,         32'h0800_0000);
        alu_vec("sll_33",     4'b0001, 32'd1,          32'd33,         32'd2);
        alu_vec("slt",        4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd1);
        alu_vec("sltu",       4'b0011, 32'hFFFF_FFFF,  32'd1,          32'd0);
        alu_vec("or",         4'b0110, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF);
        alu_vec("and",        4'b0111, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000);
        alu_vec("xor",        4'b0100, 32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0);
        alu_vec("lui",        4'b1001, 32'h1234_5000,  32'd7,          32'h1234_5000);

        // Targets: 0x100 + -8 = 0xF8; 0x203 + -8 = 0x1FB -> 0x1FA. 0x203 > 0 both ways.
        issue("targets", 1'b1, 1'b0, 4'b0000, 0, 0, 32'h203, 0, 32'h100, 32'hFFFF_FFF8,
              0, 32'hF8, 32'h1FA, 1'b0, 1'b0, 1'b0, 1'b1);
        // Flags: -1 vs 1 is signed-less but not unsigned-less; JALR = 0xFFFFFFFF -> 0xFFFFFFFE.
        issue("flags_neg", 1'b1, 1'b0, 4'b0000, 0, 0, 32'hFFFF_FFFF, 32'd1, 0, 0,
              0, 0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1);
        issue("flags_eq", 1'b1, 1'b0, 4'b0000, 0, 0, 32'd7, 32'd7, 0, 0,
              0, 0, 32'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        issue("flags_lt", 1'b1, 1'b0, 4'b0000, 0, 0, 32'd1, 32'd2, 0, 0,
              0, 0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Stall: outputs freeze for three cycles while inputs change, then resume.
        alu_vec("pre_stall", 4'b0000, 32'd3, 32'd4, 32'd7);
        stall_vec("stall0", 32'd10, 32'd20);
        stall_vec("stall1", 32'd30, 32'd40);
        stall_vec("stall2", 32'd100, 32'd1);
        alu_vec("post_stall", 4'b0000, 32'd100, 32'd1, 32'd101);

        // Undefined codes give zero (ZERO set when present).
        alu_vec("illegal_f", 4'b1111, 32'd5, 32'd5, 32'd0);
        alu_vec("illegal_a", 4'b1010, 32'hDEAD_BEEF, 32'd1, 32'd0);

        // Reset has priority over stall.
        alu_vec("pre_rst", 4'b0000, 32'd1, 32'd1, 32'd2);
        issue("rst_stall", 1'b0, 1'b1, 4'b0000, 32'd9, 32'd9, 32'd3, 32'd4, 32'd8, 32'd8,
              0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        alu_vec("after_rst", 4'b1000, 32'd10, 32'd3, 32'd7);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/otter_exec_unit.md
Name: otter_exec_unit

Overview:
- Execute-stage arithmetic block of the pipelined OTTER RV32I core.
- Merges three functions into one registered stage:
  - ALU result.
  - Branch/jump target addresses (JAL, JALR, branch).
  - Branch condition flags (equal, signed less-than, unsigned less-than).
- Takes forwarded operands from the decode/execute pipeline register; outputs feed the PC source decoder, PC mux and the EX/MEM register.

Parameters:
- WIDTH, 32, datapath width; only 32 is required to be supported; shift amount uses the low $clog2(WIDTH) bits of SRC_B.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous active-low reset (asserted when 0).
- STALL  input  1  when 1, all output registers hold their value.
- ALU_FUN  input  4  ALU operation select.
- SRC_A  input  WIDTH  ALU operand A (rs1 or U-immediate, muxed upstream).
- SRC_B  input  WIDTH  ALU operand B (rs2, immediate or PC, muxed upstream).
- RS1  input  WIDTH  forwarded rs1; used for compare and JALR.
- RS2  input  WIDTH  forwarded rs2; used for compare.
- PC  input  WIDTH  PC of the instruction in execute.
- IMM  input  WIDTH  sign-extended immediate; interpreted as J-, I- or B-type by each target.
- RESULT  output  WIDTH  registered ALU result.
- JAL  output  WIDTH  registered PC + IMM.
- JALR  output  WIDTH  registered (RS1 + IMM) with bit 0 cleared.
- BRANCH  output  WIDTH  registered PC + IMM.
- BR_EQ  output  1  registered RS1 == RS2.
- BR_LT  output  1  registered signed RS1 < RS2.
- BR_LTU  output  1  registered unsigned RS1 < RS2.

Behaviour:
- All outputs are registered; latency is exactly 1 cycle from inputs to outputs.
- Reset (RST=0 at a rising edge): every output clears to 0. Reset has priority over STALL.
- STALL=1 with RST=1: all outputs hold their previous values. A stall in the same cycle as new inputs discards those inputs.
- ALU_FUN encoding:
  - 0000 ADD
  - 1000 SUB
  - 0110 OR
  - 0111 AND
  - 0100 XOR
  - 0001 SLL
  - 0101 SRL
  - 1101 SRA (arithmetic shift right)
  - 0010 SLT (signed; result is 1 or 0, zero-extended)
  - 0011 SLTU (unsigned)
  - 1001 LUI copy (RESULT = SRC_A)
  - any other code: RESULT = 0.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow or carry outputs.
  - Shift amount is SRC_B[4:0]; upper bits are ignored, so SRC_B=33 shifts by 1.
  - SRA replicates SRC_A[WIDTH-1].
- Target addresses:
  - All use wrap-around addition.
  - JALR always has bit 0 forced to 0.
  - JAL and BRANCH are identical sums; both are provided so the PC mux wiring stays unchanged.
- Flags:
  - All three flags are computed on RS1/RS2 only, independent of ALU_FUN.
  - RS1 == RS2 gives BR_EQ=1, BR_LT=0, BR_LTU=0.
- No internal state other than the output registers.

Optional Feature:
- Macro EXEC_ZERO_FLAG_EN.
- Defined: adds output port ZERO (1 bit), a registered flag equal to 1 when the next RESULT value is 0. It follows the same reset (0) and STALL hold rules as the other outputs.
- Undefined: the port does not exist and no extra logic is generated.

Test Plan:
- Reset: RST=0 for 2 cycles with random inputs -> all outputs 0. Release RST=1 with ALU_FUN=0000, SRC_A=5, SRC_B=7 -> RESULT=12 one cycle later.
- Arithmetic wrap: SUB with SRC_A=0, SRC_B=1 -> RESULT=0xFFFFFFFF. ADD with 0xFFFFFFFF + 2 -> RESULT=1.
- Shifts and compares:
  - SRA 0x80000000 by SRC_B=0x24 -> 0xF8000000 (shift 4).
  - SRL same operands -> 0x08000000.
  - SLT with A=-1, B=1 -> RESULT=1; SLTU with the same operands -> RESULT=0.
- Targets: PC=0x100, IMM=0xFFFFFFF8, RS1=0x203 -> JAL=BRANCH=0xF8, JALR=0x1FA (bit 0 cleared).
- Flags:
  - RS1=0xFFFFFFFF, RS2=1 -> BR_EQ=0, BR_LT=1, BR_LTU=0.
  - RS1=RS2=7 -> BR_EQ=1, BR_LT=0, BR_LTU=0.
- Stall and illegal code:
  - STALL=1 for 3 cycles while inputs change -> outputs frozen; STALL=0 -> the new value appears the next cycle.
  - ALU_FUN=1111 -> RESULT=0, and ZERO=1 when EXEC_ZERO_FLAG_EN is defined.
